ser2par_word: RTL and testbench

Parametrised serial-to-parallel deserializer with word framing and an output handshake. It accumulates `DATA_W` enabled serial bits, LSB-first or MSB-first, and presents each completed word in a holding register under a valid/ready handshake. It flags words lost to back-pressure and supports aborting a partial word. It sits between a bit-level receiver front end and word-oriented consumers such as a FIFO or register file.

---
 rtl/ser2par_word.sv | 99 +++++++++
 tb/tb_ser2par_word.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ser2par_word.sv
// Serial-to-parallel deserializer: gathers DATA_W strobed bits into a word and
// hands each completed word to a consumer via a valid/ready holding register.
module ser2par_word #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                        Clk,
  input  logic                        RstB,
  input  logic                        SerDataIn,
  input  logic                        SerDataEn,
  input  logic                        FrameClr,
  input  logic                        OvrClr,
  input  logic                        ParReady,
  output logic [DATA_W-1:0]           ParDataOut,
  output logic                        ParValid,
  output logic                        Overrun,
  output logic [$clog2(DATA_W+1)-1:0] BitCnt
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d, sh_shift;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovr_q, ovr_d;
  logic              accept, complete, load, drop;

  // An abort outranks the strobe: the bit presented alongside it is discarded.
  assign accept   = SerDataEn & ~FrameClr;
  assign complete = accept & (cnt_q == CNT_LAST);
  assign load     = complete & ((state_q == S_EMPTY) | ParReady);
  assign drop     = complete & (state_q == S_FULL) & ~ParReady;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sh_shift = (sh_q << 1) | DATA_W'(SerDataIn);
    end else begin : g_lsb_first
      assign sh_shift = (sh_q >> 1) | (DATA_W'(SerDataIn) << (DATA_W - 1));
    end
  endgenerate

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (FrameClr) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (accept) begin
      sh_d  = sh_shift;
      cnt_d = complete ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // The completing bit is folded in via sh_shift, so the word is ready one edge after its last strobe.
  always_comb begin
    dout_d = load ? sh_shift : dout_q;
    ovr_d  = drop | (ovr_q & ~OvrClr);
  end

  always_ff @(posedge Clk or negedge RstB) begin
    if (!RstB) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      ovr_q  <= ovr_d;
    end
  end

  always_ff @(posedge Clk or negedge RstB) begin
    if (!RstB) state_q <= S_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (complete)              state_d = S_FULL;
      S_FULL:  if (ParReady && !complete) state_d = S_EMPTY;
      default:                            state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    ParValid = (state_q == S_FULL);
  end

  assign ParDataOut = dout_q;
  assign Overrun    = ovr_q;
  assign BitCnt     = cnt_q;

endmodule

// File: tb/tb_ser2par_word.sv
// Directed bench for ser2par_word: three instances (8-bit LSB-first, 8-bit
// MSB-first, 12-bit LSB-first) with per-instance expected-word queues.
module tb_ser2par_word;
  logic Clk = 1'b0;
  logic RstB = 1'b0;
  logic SerDataIn = 1'b0;
  logic SerDataEn = 1'b0;
  logic FrameClr = 1'b0;
  logic OvrClr = 1'b0;
  logic ParReady = 1'b0;
  logic s12_in = 1'b0;
  logic s12_en = 1'b0;

  logic [7:0]  a_dout, m_dout;
  logic        a_vld, m_vld, a_ovr, m_ovr;
  logic [3:0]  a_cnt, m_cnt;
  logic [11:0] w_dout;
  logic        w_vld, w_ovr;
  logic [3:0]  w_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] qa[$];
  logic [31:0] qm[$];
  logic [31:0] qw[$];

  ser2par_word #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_a (
    .Clk(Clk), .RstB(RstB), .SerDataIn(SerDataIn), .SerDataEn(SerDataEn),
    .FrameClr(FrameClr), .OvrClr(OvrClr), .ParReady(ParReady),
    .ParDataOut(a_dout), .ParValid(a_vld), .Overrun(a_ovr), .BitCnt(a_cnt));

  ser2par_word #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_m (
    .Clk(Clk), .RstB(RstB), .SerDataIn(SerDataIn), .SerDataEn(SerDataEn),
    .FrameClr(FrameClr), .OvrClr(OvrClr), .ParReady(ParReady),
    .ParDataOut(m_dout), .ParValid(m_vld), .Overrun(m_ovr), .BitCnt(m_cnt));

  ser2par_word #(.DATA_W(12), .MSB_FIRST(1'b0)) dut_w (
    .Clk(Clk), .RstB(RstB), .SerDataIn(s12_in), .SerDataEn(s12_en),
    .FrameClr(1'b0), .OvrClr(1'b0), .ParReady(1'b1),
    .ParDataOut(w_dout), .ParValid(w_vld), .Overrun(w_ovr), .BitCnt(w_cnt));

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: a transfer happens on the edge following a negedge with valid & ready.
  always @(negedge Clk) begin
    if (a_vld && ParReady) begin
      if (qa.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected: got 0x%0h required no word", a_dout);
      end else chk("a_word", 32'(a_dout), qa.pop_front());
    end
    if (m_vld && ParReady) begin
      if (qm.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL m_unexpected: got 0x%0h required no word", m_dout);
      end else chk("m_word", 32'(m_dout), qm.pop_front());
    end
    if (w_vld) begin
      if (qw.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL w_unexpected: got 0x%0h required no word", w_dout);
      end else chk("w_word", 32'(w_dout), qw.pop_front());
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] w, input int first, input int n, input bit gaps);
    for (int i = first; i < first + n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      SerDataIn = w[i];
      SerDataEn = 1'b1;
      step();
      SerDataEn = 1'b0;
    end
  endtask

  task automatic send12(input logic [11:0] w);
    for (int i = 0; i < 12; i++) begin
      s12_in = w[i];
      s12_en = 1'b1;
      step();
      s12_en = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_vld", 32'(a_vld), 0);
    chk("rst_dout", 32'(a_dout), 0);
    chk("rst_ovr", 32'(a_ovr), 0);
    chk("rst_cnt", 32'(a_cnt), 0);
    RstB = 1'b1;
    step();

    // Reset mid-word, then a clean word
    send_bits(32'h4D, 0, 3, 1'b0);
    chk("cnt_3", 32'(a_cnt), 3);
    #2 RstB = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(a_cnt), 0);
    chk("async_rst_m_cnt", 32'(m_cnt), 0);
    step();
    RstB = 1'b1;
    ParReady = 1'b1;
    qa.push_back(32'h4D);
    qm.push_back(32'hB2);
    send_bits(32'h4D, 0, 8, 1'b0);
    chk("w1_vld", 32'(a_vld), 1);
    chk("w1_m_vld", 32'(m_vld), 1);
    chk("w1_cnt", 32'(a_cnt), 0);
    chk("w1_ovr", 32'(a_ovr), 0);
    step();
    chk("w1_vld_one_cycle", 32'(a_vld), 0);
    ParReady = 1'b0;

    // Gapped strobe with back-pressure and overrun
    qa.push_back(32'h4D);
    qm.push_back(32'hB2);
    send_bits(32'h4D, 0, 8, 1'b1);
    chk("bp_vld", 32'(a_vld), 1);
    chk("bp_dout", 32'(a_dout), 32'h4D);
    chk("bp_ovr0", 32'(a_ovr), 0);
    send_bits(32'hFF, 0, 8, 1'b1);
    chk("ovr_dout_kept", 32'(a_dout), 32'h4D);
    chk("ovr_m_dout_kept", 32'(m_dout), 32'hB2);
    chk("ovr_set", 32'(a_ovr), 1);
    chk("ovr_vld", 32'(a_vld), 1);
    ParReady = 1'b1;
    step();
    ParReady = 1'b0;
    chk("drain_vld", 32'(a_vld), 0);
    chk("ovr_sticky", 32'(a_ovr), 1);
    OvrClr = 1'b1;
    step();
    OvrClr = 1'b0;
    chk("ovr_clr", 32'(a_ovr), 0);

    // Simultaneous consume and complete
    qa.push_back(32'h11);
    qm.push_back(32'h88);
    send_bits(32'h11, 0, 8, 1'b0);
    chk("sim_hold", 32'(a_dout), 32'h11);
    qa.push_back(32'h22);
    qm.push_back(32'h44);
    send_bits(32'h22, 0, 7, 1'b0);
    ParReady = 1'b1;
    send_bits(32'h22, 7, 1, 1'b0);
    chk("sim_dout", 32'(a_dout), 32'h22);
    chk("sim_vld", 32'(a_vld), 1);
    chk("sim_ovr", 32'(a_ovr), 0);
    step();
    ParReady = 1'b0;
    chk("sim_drained", 32'(a_vld), 0);

    // Abort a partial word while another word is held
    qa.push_back(32'h96);
    qm.push_back(32'h69);
    send_bits(32'h96, 0, 8, 1'b0);
    send_bits(32'hFF, 0, 5, 1'b0);
    chk("abort_cnt5", 32'(a_cnt), 5);
    FrameClr  = 1'b1;
    SerDataIn = 1'b1;
    SerDataEn = 1'b1;
    step();
    FrameClr  = 1'b0;
    SerDataEn = 1'b0;
    chk("abort_cnt0", 32'(a_cnt), 0);
    chk("abort_vld_kept", 32'(a_vld), 1);
    chk("abort_dout_kept", 32'(a_dout), 32'h96);
    chk("abort_ovr", 32'(a_ovr), 0);
    ParReady = 1'b1;
    step();
    qa.push_back(32'h3C);
    qm.push_back(32'h3C);
    send_bits(32'h3C, 0, 8, 1'b0);
    chk("abort_next_vld", 32'(a_vld), 1);
    step();
    ParReady = 1'b0;

    // Overrun set and clear in the same cycle
    qa.push_back(32'h11);
    qm.push_back(32'h88);
    send_bits(32'h11, 0, 8, 1'b0);
    send_bits(32'h22, 0, 7, 1'b0);
    OvrClr = 1'b1;
    send_bits(32'h22, 7, 1, 1'b0);
    OvrClr = 1'b0;
    chk("coll_ovr", 32'(a_ovr), 1);
    chk("coll_dout", 32'(a_dout), 32'h11);
    OvrClr = 1'b1;
    step();
    OvrClr = 1'b0;
    chk("coll_clr", 32'(a_ovr), 0);
    ParReady = 1'b1;
    step();
    ParReady = 1'b0;
    chk("coll_drained", 32'(a_vld), 0);

    // 12-bit LSB-first word
    qw.push_back(32'hA5C);
    send12(12'hA5C);
    chk("w12_vld", 32'(w_vld), 1);
    chk("w12_cnt", 32'(w_cnt), 0);
    step();
    chk("w12_drained", 32'(w_vld), 0);
    chk("w12_ovr", 32'(w_ovr), 0);

    repeat (3) step();
    chk("qa_empty", 32'(qa.size()), 0);
    chk("qm_empty", 32'(qm.size()), 0);
    chk("qw_empty", 32'(qw.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
